t_ff_counter_bank: RTL



---
 rtl/t_ff_counter_bank_pkg.sv | 11 +
 rtl/t_ff_counter_bank_cell.sv | 23 ++
 rtl/t_ff_counter_bank.sv | 88 ++++++++
 3 files changed

// File: rtl/t_ff_counter_bank_pkg.sv
// Shared definitions for the toggle-cell counter bank.
package t_ff_counter_bank_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } mode_e;

endpackage

// File: rtl/t_ff_counter_bank_cell.sv
// Single toggle cell: sync reset to RstVal, parallel load, else conditional toggle.
module t_ff_cell (
  input  logic Clock,
  input  logic Reset,
  input  logic En,
  input  logic Tin,
  input  logic LoadEn,
  input  logic Din,
  input  logic RstVal,
  output logic Q
);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q <= RstVal;
    end else if (LoadEn) begin
      Q <= Din;
    end else if (En) begin
      Q <= Q ^ Tin;
    end
  end

endmodule

// File: rtl/t_ff_counter_bank.sv
// WIDTH-bit bank of toggle cells: per-bit toggle, load, up/down count with sticky overflow.
module t_ff_counter_bank
  import t_ff_counter_bank_pkg::*;
#(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
  parameter int unsigned          SATURATE    = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] T,
  input  logic [WIDTH-1:0] D,
  input  logic             OvfClr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QNot,
  output logic             TermCount,
  output logic             Overflow
);

  mode_e            mode;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] tin;
  logic             at_max;
  logic             at_min;
  logic             load_en;

  assign mode    = mode_e'(Mode);
  assign at_max  = &q;
  assign at_min  = ~|q;
  assign load_en = En && (mode == MODE_LOAD);

  // Ripple carry/borrow chains: cell i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q[i-1];
      dn_t[i] = dn_t[i-1] & ~q[i-1];
    end
  end

  // Saturation suppresses the terminal toggle so Q holds at the limit.
  always_comb begin
    tin = '0;
    unique case (mode)
      MODE_TOGGLE: tin = T;
      MODE_LOAD:   tin = '0;
      MODE_UP:     tin = ((SATURATE != 0) && at_max) ? '0 : up_t;
      MODE_DOWN:   tin = ((SATURATE != 0) && at_min) ? '0 : dn_t;
      default:     tin = '0;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .Clock  (Clock),
      .Reset  (Reset),
      .En     (En),
      .Tin    (tin[i]),
      .LoadEn (load_en),
      .Din    (D[i]),
      .RstVal (RESET_VALUE[i]),
      .Q      (q[i])
    );
  end

  assign Q         = q;
  assign QNot      = ~q;
  assign TermCount = En && (((mode == MODE_UP) && at_max) || ((mode == MODE_DOWN) && at_min));

  // A set event wins over a coincident clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Overflow <= 1'b0;
    end else if (TermCount) begin
      Overflow <= 1'b1;
    end else if (OvfClr) begin
      Overflow <= 1'b0;
    end
  end

endmodule
